// File: rtl/twitch_dmem.sv
// Data-memory responder for the twitchcore load/store port: fixed-latency,
// one request in flight, byte-strobed word array and a sticky TOHOST halt.
//
// state | meaning
// IDLE  | ready; accepts and latches a request
// WAIT  | counting down remaining wait states
// RESP  | rsp_valid pulse; data/err registered on entry
module twitch_dmem #(
  parameter int          DEPTH       = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wstrb;

  logic [31:0] mem [DEPTH];

  // With LATENCY==1 the response is formed on the accepting edge, so decode
  // must see the live request rather than the (not yet loaded) latches.
  logic          d_we;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_wstrb;
  logic          d_tohost;
  logic          d_mem_ok;
  logic          d_err;
  logic [31:0]   d_rdata;
  logic [AW-1:0] d_idx;
  logic          enter_resp;
  logic          mem_we;

  assign d_we    = (state == IDLE) ? req_we    : lat_we;
  assign d_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign d_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign d_wstrb = (state == IDLE) ? req_wstrb : lat_wstrb;

  assign d_idx    = d_addr[AW+1:2];
  assign d_tohost = (d_addr == TOHOST_ADDR);
  assign d_mem_ok = !d_tohost && (d_addr[1:0] == 2'b00) && ({1'b0, d_addr} < MEM_BYTES);
  assign d_err    = !d_tohost && !d_mem_ok;

  always_comb begin
    d_rdata = 32'h0;
    if (!d_we) begin
      if (d_tohost)      d_rdata = halt_code;
      else if (d_mem_ok) d_rdata = mem[d_idx];
    end
  end

  assign enter_resp = ((state == IDLE) && req_valid && (LATENCY == 1)) ||
                      ((state == WAIT) && (cnt == 4'd1));
  // Gated by resetn so a request presented during reset never commits.
  assign mem_we     = enter_resp && d_we && d_mem_ok && resetn;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (d_wstrb[b]) mem[d_idx][8*b +: 8] <= d_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      halt      <= 1'b0;
      halt_code <= 32'h0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_wstrb <= 4'h0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase

      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= d_rdata;
        rsp_err   <= d_err;
        if (d_tohost && d_we && !halt) begin
          halt      <= 1'b1;
          halt_code <= d_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_twitch_dmem.sv
// Scoreboard bench for twitch_dmem: two instances (LATENCY 3 and 4) share the
// clock; directed requests push hand-computed responses, monitors pop them.
module tb_twitch_dmem;

  localparam int          DEPTH  = 256;
  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam int          LAT_A  = 3;
  localparam int          LAT_B  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        resetn_a, resetn_b;
  logic        req_valid_a, req_ready_a, req_we_a, rsp_valid_a, rsp_err_a, halt_a;
  logic [31:0] req_addr_a, req_wdata_a, rsp_rdata_a, halt_code_a;
  logic [3:0]  req_wstrb_a;
  logic        req_valid_b, req_ready_b, req_we_b, rsp_valid_b, rsp_err_b, halt_b;
  logic [31:0] req_addr_b, req_wdata_b, rsp_rdata_b, halt_code_b;
  logic [3:0]  req_wstrb_b;

  twitch_dmem #(.DEPTH(DEPTH), .LATENCY(LAT_A), .TOHOST_ADDR(TOHOST)) dut_a (
    .clk(clk), .resetn(resetn_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a), .req_wstrb(req_wstrb_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .halt(halt_a), .halt_code(halt_code_a)
  );

  twitch_dmem #(.DEPTH(DEPTH), .LATENCY(LAT_B), .TOHOST_ADDR(TOHOST)) dut_b (
    .clk(clk), .resetn(resetn_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_wstrb(req_wstrb_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .halt(halt_b), .halt_code(halt_code_b)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        halt;
    logic [31:0] code;
    int          cycle;
    string       name;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   passed = 0;
  int   stray_b = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h", nm, act, req);
  endfunction

  always @(negedge clk) begin
    if (resetn_a && rsp_valid_a) begin
      if (q_a.size() == 0) begin
        checks++;
        $display("FAIL stray_rsp_a: rsp_valid=1 with nothing pending, required 0");
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check({e.name, " rdata"}, rsp_rdata_a, e.rdata);
        check({e.name, " err"}, 32'(rsp_err_a), 32'(e.err));
        check({e.name, " halt"}, 32'(halt_a), 32'(e.halt));
        check({e.name, " halt_code"}, halt_code_a, e.code);
        check({e.name, " rsp_cycle"}, 32'(cyc), 32'(e.cycle));
        check({e.name, " ready_in_resp"}, 32'(req_ready_a), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (resetn_b && rsp_valid_b) begin
      if (q_b.size() == 0) begin
        stray_b++;
        checks++;
        $display("FAIL stray_rsp_b: rsp_valid=1 with nothing pending, required 0");
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check({e.name, " rdata"}, rsp_rdata_b, e.rdata);
        check({e.name, " err"}, 32'(rsp_err_b), 32'(e.err));
        check({e.name, " rsp_cycle"}, 32'(cyc), 32'(e.cycle));
      end
    end
  end

  // Called at a negedge; returns at the negedge where the DUT is ready again.
  task automatic issue(input bit sel_b, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic [31:0] er, input logic ee, input logic eh,
                       input logic [31:0] ec, input string nm);
    int   n;
    int   lat;
    exp_t e;
    lat = sel_b ? LAT_B : LAT_A;
    n = 0;
    while (!(sel_b ? req_ready_b : req_ready_a) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({nm, " ready_before"}, 32'(sel_b ? req_ready_b : req_ready_a), 32'd1);
    e.rdata = er; e.err = ee; e.halt = eh; e.code = ec;
    e.cycle = cyc + lat; e.name = nm;
    if (sel_b) begin
      req_valid_b = 1'b1; req_we_b = we; req_addr_b = addr; req_wdata_b = wdata; req_wstrb_b = strb;
      q_b.push_back(e);
    end else begin
      req_valid_a = 1'b1; req_we_a = we; req_addr_a = addr; req_wdata_a = wdata; req_wstrb_a = strb;
      q_a.push_back(e);
    end
    @(negedge clk);
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    n = 0;
    while (!(sel_b ? req_ready_b : req_ready_a) && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({nm, " busy_cycles"}, 32'(n), 32'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn_a = 1'b0; resetn_b = 1'b0;
    req_valid_a = 1'b0; req_we_a = 1'b0; req_addr_a = '0; req_wdata_a = '0; req_wstrb_a = '0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; req_wstrb_b = '0;
    repeat (2) @(negedge clk);
    resetn_a = 1'b1; resetn_b = 1'b1;
    @(negedge clk);
    check("reset req_ready", 32'(req_ready_a), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid_a), 32'd0);
    check("reset rsp_rdata", rsp_rdata_a, 32'h0);
    check("reset rsp_err", 32'(rsp_err_a), 32'd0);
    check("reset halt", 32'(halt_a), 32'd0);
    check("reset halt_code", halt_code_a, 32'h0);

    issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0, 32'h0, "st_10");
    issue(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, 32'h0, "ld_10");
    issue(0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, 0, 32'h0, "st_20_full");
    issue(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 0, 32'h0, "st_20_strb");
    issue(0, 0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0, 0, 32'h0, "ld_20_merged");
    issue(0, 1, 32'h0, 32'hA5A5A5A5, 4'hF, 32'h0, 0, 0, 32'h0, "st_0");
    issue(0, 0, 32'h22, 32'h0, 4'h0, 32'h0, 1, 0, 32'h0, "ld_misaligned");
    issue(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 0, 32'h0, "st_oob");
    issue(0, 0, 32'h0, 32'h0, 4'h0, 32'hA5A5A5A5, 0, 0, 32'h0, "ld_0_after_oob");
    issue(0, 0, 32'h8000_0010, 32'h0, 4'h0, 32'h0, 1, 0, 32'h0, "ld_high_oob");
    issue(0, 1, 32'h10, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0, "st_nostrb");
    issue(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, 32'h0, "ld_10_after_nostrb");
    issue(0, 1, TOHOST, 32'h1, 4'h0, 32'h0, 0, 1, 32'h1, "st_tohost_1");
    issue(0, 1, TOHOST, 32'h5, 4'hF, 32'h0, 0, 1, 32'h1, "st_tohost_5");
    issue(0, 0, TOHOST, 32'h0, 4'h0, 32'h1, 0, 1, 32'h1, "ld_tohost");
    issue(0, 0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0, 1, 32'h1, "ld_20_after_halt");

    // Reset while a LATENCY=4 store is in flight.
    issue(1, 1, 32'h30, 32'h12345678, 4'hF, 32'h0, 0, 0, 32'h0, "b_st_30");
    req_valid_b = 1'b1; req_we_b = 1'b1; req_addr_b = 32'h30;
    req_wdata_b = 32'hCAFEF00D; req_wstrb_b = 4'hF;
    @(negedge clk);
    req_valid_b = 1'b0;
    check("b_abort busy_after_accept", 32'(req_ready_b), 32'd0);
    @(negedge clk);
    resetn_b = 1'b0;
    #1;
    check("b_abort ready_in_reset", 32'(req_ready_b), 32'd1);
    check("b_abort rsp_valid_in_reset", 32'(rsp_valid_b), 32'd0);
    repeat (2) @(negedge clk);
    resetn_b = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid_b) n++;
    end
    check("b_abort no_rsp", 32'(n), 32'd0);
    check("b_abort idle_ready", 32'(req_ready_b), 32'd1);
    issue(1, 0, 32'h30, 32'h0, 4'h0, 32'h12345678, 0, 0, 32'h0, "b_ld_30_prestore");

    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain q_a", 32'(q_a.size()), 32'd0);
    check("drain q_b", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
